// File: rtl/hex_display_sequencer.sv
// Avalon-MM write master that decodes a packed hex value and writes it, one digit at a time, to HEXn 7-segment PIO slaves.
// Optional build macro HEX_SEQ_LEADING_ZERO_BLANK_EN blanks zero digits above the highest non-zero digit.
module hex_display_sequencer #(
    parameter int DIGITS     = 6,
    parameter int GAP_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   value,
    output logic [DIGITS-1:0]     chipselect,
    output logic [1:0]            address,
    output logic                  write_n,
    output logic [6:0]            writedata,
    output logic                  busy,
    output logic                  done
);

    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DW-1:0] LAST_DIGIT = DW'(DIGITS - 1);
    localparam logic [7:0]    GAP_LAST   = 8'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WRITE,
        GAP,
        DONE
    } state_t;

    state_t              r_state;
    logic [4*DIGITS-1:0] r_shadow;
    logic [4*DIGITS-1:0] r_pendValue;
    logic                r_pending;
    logic [DW-1:0]       r_digit;
    logic [7:0]          r_gapCount;
    logic [DIGITS-1:0]   r_chipselect;
    logic                r_writeN;
    logic [6:0]          r_writedata;
    logic                r_busy;
    logic                r_done;

    logic [3:0]          w_nibble;
    logic [DIGITS-1:0]   w_blankMask;
    logic                w_blank;
    logic [6:0]          w_segments;

    function automatic logic [6:0] decodeHex(input logic [3:0] nibble);
        case (nibble)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    assign w_nibble = 4'(r_shadow >> {r_digit, 2'b00});

`ifdef HEX_SEQ_LEADING_ZERO_BLANK_EN
    // Scan from the top digit down; a digit is blank while nothing non-zero has been seen yet. HEX0 is never blanked.
    always_comb begin
        logic seenNonZero;
        seenNonZero = 1'b0;
        w_blankMask = '0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            if (r_shadow[4*i +: 4] != 4'h0) begin
                seenNonZero = 1'b1;
            end
            w_blankMask[i] = !seenNonZero;
        end
    end
`else
    assign w_blankMask = '0;
`endif

    assign w_blank    = 1'(w_blankMask >> r_digit);
    assign w_segments = w_blank ? 7'h7F : decodeHex(w_nibble);

    // Strobe and chipselect default to inactive every cycle, so only the SETUP->WRITE edge raises them for one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_shadow     <= '0;
            r_pendValue  <= '0;
            r_pending    <= 1'b0;
            r_digit      <= '0;
            r_gapCount   <= '0;
            r_chipselect <= '0;
            r_writeN     <= 1'b1;
            r_writedata  <= 7'h7F;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done       <= 1'b0;
            r_chipselect <= '0;
            r_writeN     <= 1'b1;

            if (start && (r_state == SETUP || r_state == WRITE || r_state == GAP)) begin
                r_pending   <= 1'b1;
                r_pendValue <= value;
            end

            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_shadow <= value;
                        r_digit  <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= SETUP;
                    end
                end
                SETUP: begin
                    r_writedata  <= w_segments;
                    r_chipselect <= DIGITS'(1) << r_digit;
                    r_writeN     <= 1'b0;
                    r_state      <= WRITE;
                end
                WRITE: begin
                    if (r_digit == LAST_DIGIT) begin
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_digit <= r_digit + 1'b1;
                        if (GAP_CYCLES > 0) begin
                            r_gapCount <= '0;
                            r_state    <= GAP;
                        end else begin
                            r_state <= SETUP;
                        end
                    end
                end
                GAP: begin
                    if (r_gapCount == GAP_LAST) begin
                        r_state <= SETUP;
                    end else begin
                        r_gapCount <= r_gapCount + 1'b1;
                    end
                end
                DONE: begin
                    // A start in this very cycle is newer than any stored request, so it wins.
                    if (start || r_pending) begin
                        r_shadow  <= start ? value : r_pendValue;
                        r_pending <= 1'b0;
                        r_digit   <= '0;
                        r_state   <= SETUP;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign chipselect = r_chipselect;
    assign address    = 2'd0;
    assign write_n    = r_writeN;
    assign writedata  = r_writedata;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_hex_display_sequencer.sv
// Self-checking bench for hex_display_sequencer: one DUT with default timing, one with GAP_CYCLES=3,
// both compared against a write-list model derived from the digit/timing rules.
module tb_hex_display_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        startA = 1'b0, startB = 1'b0;
    logic [23:0] valueA = '0, valueB = '0;
    logic [5:0]  csA, csB;
    logic [1:0]  addrA, addrB;
    logic        writeNA, writeNB, busyA, busyB, doneA, doneB;
    logic [6:0]  dataA, dataB;

    always #5 clk = ~clk;

    hex_display_sequencer #(.DIGITS(6), .GAP_CYCLES(0)) dutA (
        .clk(clk), .reset(reset), .start(startA), .value(valueA),
        .chipselect(csA), .address(addrA), .write_n(writeNA), .writedata(dataA),
        .busy(busyA), .done(doneA)
    );

    hex_display_sequencer #(.DIGITS(6), .GAP_CYCLES(3)) dutB (
        .clk(clk), .reset(reset), .start(startB), .value(valueB),
        .chipselect(csB), .address(addrB), .write_n(writeNB), .writedata(dataB),
        .busy(busyB), .done(doneB)
    );

    typedef struct packed {
        logic [31:0] cyc;
        logic [5:0]  cs;
        logic [6:0]  data;
    } wr_t;

    int   cycleNum = 0;
    int   errors = 0;
    int   checks = 0;
    int   protoBad = 0;
    int   busyLowA = 0;
    bit   blankEn;
    wr_t  gotWrA[$], gotWrB[$], expWr[$];
    int   gotDoneA[$], gotDoneB[$], expDone[$];
    logic [6:0] segTable [16];

    always @(posedge clk) cycleNum <= cycleNum + 1;

    // Log every observed write strobe and done pulse, and count bus-protocol violations.
    always @(negedge clk) begin
        if (!reset) begin
            if (!writeNA) gotWrA.push_back(wr_t'{cyc: 32'(cycleNum), cs: csA, data: dataA});
            if (!writeNB) gotWrB.push_back(wr_t'{cyc: 32'(cycleNum), cs: csB, data: dataB});
            if (doneA) gotDoneA.push_back(cycleNum);
            if (doneB) gotDoneB.push_back(cycleNum);
            if (!busyA) busyLowA++;
            if ((writeNA && csA != 6'd0) || (!writeNA && !$onehot(csA)) || addrA != 2'd0) protoBad++;
            if ((writeNB && csB != 6'd0) || (!writeNB && !$onehot(csB)) || addrB != 2'd0) protoBad++;
        end
    end

    function automatic logic [6:0] expectPattern(input logic [23:0] v, input int i);
        logic [23:0] upper;
        upper = v >> (4 * i);
        if (blankEn && i > 0 && upper == 24'd0) return 7'h7F;
        return segTable[upper[3:0]];
    endfunction

    // A request accepted at cycle s writes digit k at s+2+k*(2+gap); done follows the last write by one cycle.
    function automatic void modelSequence(input logic [23:0] v, input int s, input int gap);
        for (int k = 0; k < 6; k++)
            expWr.push_back(wr_t'{cyc: 32'(s + 2 + k * (2 + gap)), cs: 6'(1 << k), data: expectPattern(v, k)});
        expDone.push_back(s + 2 + 6 * 2 + 5 * gap - 1);
    endfunction

    function automatic void clearAll();
        gotWrA.delete(); gotWrB.delete(); expWr.delete();
        gotDoneA.delete(); gotDoneB.delete(); expDone.delete();
    endfunction

    task automatic pulseA(input int c, input logic [23:0] v);
        while (cycleNum < c) @(negedge clk);
        startA = 1'b1; valueA = v;
        @(negedge clk);
        startA = 1'b0;
    endtask

    task automatic pulseB(input int c, input logic [23:0] v);
        while (cycleNum < c) @(negedge clk);
        startB = 1'b1; valueB = v;
        @(negedge clk);
        startB = 1'b0;
    endtask

    task automatic test_reset();
        bit found;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (csA !== 6'd0)    begin errors++; $display("[TB] FAIL reset_cs: got %b want 000000", csA); end
        checks++; if (writeNA !== 1'b1) begin errors++; $display("[TB] FAIL reset_write_n: got %b want 1", writeNA); end
        checks++; if (addrA !== 2'd0)  begin errors++; $display("[TB] FAIL reset_address: got %0d want 0", addrA); end
        checks++; if (dataA !== 7'h7F) begin errors++; $display("[TB] FAIL reset_writedata: got %h want 7f", dataA); end
        checks++; if (busyA !== 1'b0)  begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busyA); end
        checks++; if (doneA !== 1'b0)  begin errors++; $display("[TB] FAIL reset_done: got %b want 0", doneA); end
        reset = 1'b0;
        @(negedge clk);
        clearAll();
        pulseA(cycleNum, 24'($urandom));
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (!writeNA && csA == 6'b000100) begin found = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (!found) begin errors++; $display("[TB] FAIL reset_reach_hex2: got no HEX2 write want one within 30 cycles"); end
        reset = 1'b1;
        #1;
        checks++; if (csA !== 6'd0)    begin errors++; $display("[TB] FAIL midreset_cs: got %b want 000000", csA); end
        checks++; if (writeNA !== 1'b1) begin errors++; $display("[TB] FAIL midreset_write_n: got %b want 1", writeNA); end
        checks++; if (busyA !== 1'b0)  begin errors++; $display("[TB] FAIL midreset_busy: got %b want 0", busyA); end
        @(negedge clk);
        reset = 1'b0;
        clearAll();
        repeat (30) @(negedge clk);
        checks++; if (gotDoneA.size() != 0) begin errors++; $display("[TB] FAIL midreset_no_done: got %0d done pulses want 0", gotDoneA.size()); end
        checks++; if (gotWrA.size() != 0)   begin errors++; $display("[TB] FAIL midreset_no_write: got %0d writes want 0", gotWrA.size()); end
    endtask

    task automatic test_sequence_a(input string name, input logic [23:0] v);
        int s;
        clearAll();
        s = cycleNum;
        pulseA(s, v);
        checks++; if (busyA !== 1'b1) begin errors++; $display("[TB] FAIL %s_busy: got %b want 1", name, busyA); end
        modelSequence(v, s, 0);
        repeat (20) @(negedge clk);
        checks++; if (gotWrA.size() != expWr.size()) begin errors++; $display("[TB] FAIL %s_count: got %0d writes want %0d", name, gotWrA.size(), expWr.size()); end
        foreach (expWr[i]) if (i < gotWrA.size()) begin
            checks++;
            if (gotWrA[i] !== expWr[i]) begin errors++; $display("[TB] FAIL %s_write%0d: got cyc=%0d cs=%b data=%h want cyc=%0d cs=%b data=%h", name, i, gotWrA[i].cyc, gotWrA[i].cs, gotWrA[i].data, expWr[i].cyc, expWr[i].cs, expWr[i].data); end
        end
        checks++; if (gotDoneA.size() != 1 || gotDoneA[0] != expDone[0]) begin errors++; $display("[TB] FAIL %s_done: got %0d pulses first=%0d want 1 at %0d", name, gotDoneA.size(), (gotDoneA.size() > 0) ? gotDoneA[0] : -1, expDone[0]); end
        checks++; if (busyA !== 1'b0) begin errors++; $display("[TB] FAIL %s_busy_end: got %b want 0", name, busyA); end
    endtask

    task automatic test_gap(input string name, input logic [23:0] v);
        int s;
        clearAll();
        s = cycleNum;
        pulseB(s, v);
        modelSequence(v, s, 3);
        repeat (40) @(negedge clk);
        checks++; if (gotWrB.size() != expWr.size()) begin errors++; $display("[TB] FAIL %s_count: got %0d writes want %0d", name, gotWrB.size(), expWr.size()); end
        foreach (expWr[i]) if (i < gotWrB.size()) begin
            checks++;
            if (gotWrB[i] !== expWr[i]) begin errors++; $display("[TB] FAIL %s_write%0d: got cyc=%0d cs=%b data=%h want cyc=%0d cs=%b data=%h", name, i, gotWrB[i].cyc, gotWrB[i].cs, gotWrB[i].data, expWr[i].cyc, expWr[i].cs, expWr[i].data); end
        end
        checks++; if (gotDoneB.size() != 1 || gotDoneB[0] != expDone[0]) begin errors++; $display("[TB] FAIL %s_done: got %0d pulses first=%0d want 1 at %0d", name, gotDoneB.size(), (gotDoneB.size() > 0) ? gotDoneB[0] : -1, expDone[0]); end
    endtask

    // Extra starts land while busy; only the newest one is replayed after the first done.
    task automatic test_back_to_back(input string name, input logic [23:0] first, input int extraOffsets[3], input logic [23:0] extraValues[3]);
        int s;
        clearAll();
        s = cycleNum;
        pulseA(s, first);
        busyLowA = 0;
        for (int k = 0; k < 3; k++) pulseA(s + extraOffsets[k], extraValues[k]);
        modelSequence(first, s, 0);
        modelSequence(extraValues[2], s + 13, 0);
        while (cycleNum < s + 20) @(negedge clk);
        #1;
        checks++; if (busyLowA != 0) begin errors++; $display("[TB] FAIL %s_busy_held: got %0d low cycles want 0", name, busyLowA); end
        repeat (20) @(negedge clk);
        checks++; if (gotWrA.size() != expWr.size()) begin errors++; $display("[TB] FAIL %s_count: got %0d writes want %0d", name, gotWrA.size(), expWr.size()); end
        foreach (expWr[i]) if (i < gotWrA.size()) begin
            checks++;
            if (gotWrA[i] !== expWr[i]) begin errors++; $display("[TB] FAIL %s_write%0d: got cyc=%0d cs=%b data=%h want cyc=%0d cs=%b data=%h", name, i, gotWrA[i].cyc, gotWrA[i].cs, gotWrA[i].data, expWr[i].cyc, expWr[i].cs, expWr[i].data); end
        end
        checks++; if (gotDoneA.size() != 2) begin errors++; $display("[TB] FAIL %s_done_count: got %0d pulses want 2", name, gotDoneA.size()); end
        foreach (expDone[i]) if (i < gotDoneA.size()) begin
            checks++;
            if (gotDoneA[i] != expDone[i]) begin errors++; $display("[TB] FAIL %s_done%0d: got cyc=%0d want cyc=%0d", name, i, gotDoneA[i], expDone[i]); end
        end
        checks++; if (busyA !== 1'b0) begin errors++; $display("[TB] FAIL %s_busy_end: got %b want 0", name, busyA); end
    endtask

    task automatic test_protocol();
        checks++;
        if (protoBad != 0) begin errors++; $display("[TB] FAIL protocol: got %0d bad bus cycles want 0", protoBad); end
    endtask

    initial begin
        int          offs[3];
        logic [23:0] vals[3];
        segTable = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                     7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
`ifdef HEX_SEQ_LEADING_ZERO_BLANK_EN
        blankEn = 1'b1;
`else
        blankEn = 1'b0;
`endif
        test_reset();
        test_sequence_a("fixed", 24'h12AB0F);
        test_sequence_a("leading", 24'h000450);
        test_sequence_a("zero", 24'h000000);
        for (int n = 0; n < 4; n++)
            test_sequence_a("random", 24'($urandom) >> (4 * $urandom_range(0, 5)));
        test_gap("gap_one", 24'h000001);
        test_gap("gap_random", 24'($urandom));
        vals = '{24'h222222, 24'h0, 24'h0};
        offs = '{8, 9, 10};
        vals[1] = 24'h222222; vals[2] = 24'h222222;
        test_back_to_back("pending", 24'h111111, offs, vals);
        for (int n = 0; n < 2; n++) begin
            vals[0] = 24'($urandom); vals[1] = 24'($urandom); vals[2] = 24'($urandom);
            offs[0] = 1 + $urandom_range(0, 2);
            offs[1] = 5 + $urandom_range(0, 3);
            offs[2] = (n == 0) ? 13 : 10 + $urandom_range(0, 3);
            test_back_to_back("b2b", 24'($urandom), offs, vals);
        end
        test_protocol();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
